// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer for the character/bubble datapath.
// Owns the game phase, lives, level number and per-level countdown, issues the
// charStart / levelLoad strobes and the freeze level to the object movers.
// Optional build macro: PAUSE_EN enables the pause key and the PAUSE phase (7).
module game_flow_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int NUM_LEVELS     = 4,
    parameter int LEVEL_TIME     = 60,
    parameter int FRAMES_PER_SEC = 30,
    parameter int READY_FRAMES   = 60,
    parameter int HIT_FRAMES     = 45
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       pauseKey,
    input  logic       bubbleHit,
    input  logic       levelCleared,
    output logic       charStart,
    output logic       levelLoad,
    output logic       freeze,
    output logic [2:0] phase,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [6:0] timeLeft
);

    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_HIT   = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;
    localparam logic [2:0] ST_WIN   = 3'd6;
    localparam logic [2:0] ST_PAUSE = 3'd7;

    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [6:0]       TIME_RST   = 7'(LEVEL_TIME);
    localparam logic [2:0]       LEVEL_LAST = 3'(NUM_LEVELS - 1);

    logic [2:0]       phase_q, phase_d;
    logic [1:0]       lives_q, lives_d;
    logic [2:0]       level_q, level_d;
    logic [6:0]       time_q, time_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic             char_q, char_d;
    logic             load_q, load_d;
    logic             freeze_q, freeze_d;
    logic             start_prev_q;
    logic             start_rise;
    logic             pause_rise;

    function automatic logic [1:0] sat_dec_lives(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    function automatic logic [6:0] sat_dec_time(input logic [6:0] v);
        return (v == 7'd0) ? 7'd0 : v - 7'd1;
    endfunction

    assign start_rise = startKey & ~start_prev_q;

`ifdef PAUSE_EN
    logic pause_prev_q;

    // Pause key history for rising-edge detection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) pause_prev_q <= 1'b0;
        else         pause_prev_q <= pauseKey;
    end

    assign pause_rise = pauseKey & ~pause_prev_q;
`else
    logic unused_pause;
    assign unused_pause = pauseKey;
    assign pause_rise   = 1'b0;
`endif

    // Next-state logic: phase sequencing, lives/level/countdown bookkeeping, strobes.
    always_comb begin
        phase_d = phase_q;
        lives_d = lives_q;
        level_d = level_q;
        time_d  = time_q;
        sec_d   = sec_q;
        char_d  = 1'b0;
        load_d  = 1'b0;

        case (phase_q)
            ST_IDLE: begin
                if (start_rise) begin
                    phase_d = ST_READY;
                    lives_d = LIVES_RST;
                    level_d = 3'd0;
                    time_d  = TIME_RST;
                    load_d  = 1'b1;
                end
            end
            ST_READY: begin
                if (startOfFrame && frame_q == READY_LAST) begin
                    phase_d = ST_PLAY;
                    sec_d   = '0;
                    char_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (startOfFrame) begin
                    if (sec_q == SEC_LAST) begin
                        sec_d  = '0;
                        time_d = sat_dec_time(time_q);
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end
                // Exit conditions outrank a pause request made in the same cycle.
                if (bubbleHit || time_q == 7'd0) begin
                    phase_d = ST_HIT;
                    lives_d = sat_dec_lives(lives_q);
                end else if (levelCleared) begin
                    phase_d = ST_CLEAR;
                end else if (pause_rise) begin
                    phase_d = ST_PAUSE;
                end
            end
            ST_HIT: begin
                if (startOfFrame && frame_q == HIT_LAST) begin
                    if (lives_q == 2'd0) begin
                        phase_d = ST_OVER;
                    end else begin
                        phase_d = ST_READY;
                        time_d  = TIME_RST;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (startOfFrame && frame_q == HIT_LAST) begin
                    if (level_q == LEVEL_LAST) begin
                        phase_d = ST_WIN;
                    end else begin
                        phase_d = ST_READY;
                        level_d = level_q + 3'd1;
                        time_d  = TIME_RST;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_OVER, ST_WIN: begin
                if (start_rise) phase_d = ST_IDLE;
            end
            ST_PAUSE: begin
                // Second counter and countdown are untouched here, so PLAY resumes mid-second.
                if (pause_rise) phase_d = ST_PLAY;
            end
            default: phase_d = ST_IDLE;
        endcase

        if (phase_d != phase_q)
            frame_d = '0;
        else if (startOfFrame && phase_q != ST_PAUSE)
            frame_d = frame_q + 1'b1;
        else
            frame_d = frame_q;

        freeze_d = (phase_d != ST_PLAY);
    end

    // State and registered outputs; reset returns the game to IDLE from any point.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_q      <= ST_IDLE;
            lives_q      <= LIVES_RST;
            level_q      <= 3'd0;
            time_q       <= TIME_RST;
            frame_q      <= '0;
            sec_q        <= '0;
            char_q       <= 1'b0;
            load_q       <= 1'b0;
            freeze_q     <= 1'b1;
            start_prev_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            time_q       <= time_d;
            frame_q      <= frame_d;
            sec_q        <= sec_d;
            char_q       <= char_d;
            load_q       <= load_d;
            freeze_q     <= freeze_d;
            start_prev_q <= startKey;
        end
    end

    assign phase     = phase_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign timeLeft  = time_q;
    assign charStart = char_q;
    assign levelLoad = load_q;
    assign freeze    = freeze_q;

endmodule
